// File: rtl/pkg_tpu.sv
// Shared vector-unit types for the commit tracker, sized for the default configuration
// (4 lanes, 4 outstanding commands, 8-bit thread IDs).
package pkg_tpu;

    localparam int VCT_NUM_LANES = 4;
    localparam int VCT_DEPTH     = 4;
    localparam int VCT_ID_WIDTH  = 8;
    localparam int VCT_TAG_WIDTH = $clog2(VCT_DEPTH);

    typedef logic [VCT_TAG_WIDTH-1:0] vct_tag_t;

    typedef struct packed {
        logic                     valid;
        logic [VCT_NUM_LANES-1:0] mask;
        logic [VCT_NUM_LANES-1:0] done;
        logic [VCT_ID_WIDTH-1:0]  id;
    } vct_entry_t;

    typedef vct_tag_t [VCT_NUM_LANES-1:0] v_commit_tag_t;

endpackage

// File: rtl/vector_commit_tracker.sv
// In-order commit tracker for up to DEPTH outstanding vector commands: gathers tagged
// per-lane commit pulses and retires the oldest command once every enabled lane is done.
module vector_commit_tracker
    import pkg_tpu::*;
#(
    parameter int  NUM_LANES = VCT_NUM_LANES,
    parameter int  DEPTH     = VCT_DEPTH,
    parameter int  ID_WIDTH  = VCT_ID_WIDTH,
    localparam int TAG_WIDTH = $clog2(DEPTH)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           I_Issue,
    input  logic [NUM_LANES-1:0]           I_En_Lane,
    input  logic [ID_WIDTH-1:0]            I_ThreadID,
    output logic                           O_Issue_Ready,
    output logic [TAG_WIDTH-1:0]           O_Issue_Tag,
    input  logic [NUM_LANES-1:0]           I_Commit,
    input  logic [NUM_LANES*TAG_WIDTH-1:0] I_Commit_Tag,
    output logic                           O_Commit_Req,
    output logic [ID_WIDTH-1:0]            O_Commit_ThreadID,
    output logic [TAG_WIDTH-1:0]           O_Commit_Tag,
    input  logic                           I_Commit_Ack,
    input  logic                           I_Flush,
    output logic [TAG_WIDTH:0]             O_Count,
    output logic                           O_Error
);

    typedef logic [TAG_WIDTH-1:0] tag_t;
    typedef logic [TAG_WIDTH:0]   cnt_t;

    typedef struct packed {
        logic                 valid;
        logic [NUM_LANES-1:0] mask;
        logic [NUM_LANES-1:0] done;
        logic [ID_WIDTH-1:0]  id;
    } entry_t;

    entry_t entries_q [DEPTH];
    entry_t entries_d [DEPTH];
    tag_t   head_q, head_d;
    tag_t   tail_q, tail_d;
    cnt_t   count_q, count_d;
    logic   error_q, error_d;

    logic [NUM_LANES-1:0] laneHit;
    logic [NUM_LANES-1:0] laneErr;
    logic                 issueFire;
    logic                 retireFire;

    assign O_Issue_Ready     = (count_q != cnt_t'(DEPTH));
    assign O_Issue_Tag       = tail_q;
    assign O_Commit_Req      = entries_q[head_q].valid &&
                               (entries_q[head_q].done == entries_q[head_q].mask);
    assign O_Commit_ThreadID = entries_q[head_q].id;
    assign O_Commit_Tag      = head_q;
    assign O_Count           = count_q;
    assign O_Error           = error_q;

    assign issueFire  = I_Issue && O_Issue_Ready;
    assign retireFire = O_Commit_Req && I_Commit_Ack;

    // A pulse only counts if it lands on a live entry, an enabled lane, and a lane not yet done.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        tag_t laneTag;
        assign laneTag    = I_Commit_Tag[g*TAG_WIDTH +: TAG_WIDTH];
        assign laneHit[g] = I_Commit[g] && entries_q[laneTag].valid &&
                            entries_q[laneTag].mask[g] && !entries_q[laneTag].done[g];
        assign laneErr[g] = I_Commit[g] && !laneHit[g];
    end

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        error_d   = error_q | (|laneErr);

        for (int l = 0; l < NUM_LANES; l++) begin
            if (laneHit[l]) begin
                entries_d[I_Commit_Tag[l*TAG_WIDTH +: TAG_WIDTH]].done[l] = 1'b1;
            end
        end

        if (retireFire) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_q + tag_t'(1);
        end

        if (issueFire) begin
            entries_d[tail_q].valid = 1'b1;
            entries_d[tail_q].mask  = I_En_Lane;
            entries_d[tail_q].done  = '0;
            entries_d[tail_q].id    = I_ThreadID;
            tail_d                  = tail_q + tag_t'(1);
        end

        case ({issueFire, retireFire})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase

        // Flush wins over everything in the same cycle but leaves the sticky error alone.
        if (I_Flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                entries_d[k] = '0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            error_d = error_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                entries_q[k] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            error_q   <= error_d;
        end
    end

endmodule
